// File: rtl/scr1_memif_pkg.sv
// ============================================================================
//  Module      : scr1_memif_pkg
//  Description : SCR1 memory-interface widths and command/response types.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef SCR1_MEMIF_SVH
`define SCR1_MEMIF_SVH
`define SCR1_IMEM_AWIDTH 32
`define SCR1_IMEM_DWIDTH 32
`endif

package scr1_memif_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage

`default_nettype wire

// File: rtl/ssrv_fetch_pkg.sv
// ============================================================================
//  Module      : ssrv_fetch_pkg
//  Description : Prefetcher state encoding, buffer entry layout, depth bounds.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssrv_fetch_pkg;

    localparam int c_depth_min = 2;
    localparam int c_depth_max = 8;

    typedef enum logic [0:0] {
        FETCH    = 1'b0,
        HALT_ERR = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } fetch_entry_t;

    localparam int c_entry_w = $bits(fetch_entry_t);

    function automatic logic depth_ok(input int depth);
        return (depth >= c_depth_min) && (depth <= c_depth_max) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ssrv_fetch_fifo.sv
// ============================================================================
//  Module      : ssrv_fetch_fifo
//  Description : Instruction buffer with registered head, flush, push+pop at full.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssrv_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 65
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic                       o_valid,
    output logic [WIDTH-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] w_rd_nxt;
    logic [c_cnt_w-1:0] r_count;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic               r_valid;
    logic [WIDTH-1:0]   r_head;
    logic [WIDTH-1:0]   w_head_nxt;
    logic               w_do_push;
    logic               w_do_pop;

    // The head register is loaded with what will sit at the read pointer next
    // cycle, bypassing the array when that slot is the one being written now.
    always_comb begin
        w_do_pop   = i_pop & r_valid;
        w_do_push  = i_push & ((r_count != c_full) | w_do_pop);
        w_cnt_nxt  = r_count + c_cnt_w'(w_do_push) - c_cnt_w'(w_do_pop);
        w_rd_nxt   = r_rd_ptr + c_ptr_w'(w_do_pop);
        w_head_nxt = r_mem[w_rd_nxt];
        if (w_cnt_nxt == '0) begin
            w_head_nxt = '0;
        end else if (w_do_push && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_head   <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_cnt_nxt;
            r_valid  <= (w_cnt_nxt != '0);
            r_head   <= w_head_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_valid = r_valid;
    assign o_rdata = r_head;
    assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ssrv_imem_prefetch.sv
// ============================================================================
//  Module      : ssrv_imem_prefetch
//  Description : Credit-limited SCR1 IMEM instruction prefetcher with redirect.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ssrv_imem_prefetch
    import scr1_memif_pkg::*;
    import ssrv_fetch_pkg::*;
#(
    parameter int          DEPTH      = 4,
    parameter logic [31:0] RST_VECTOR = 32'h0000_0200
) (
    input  logic                          clk,
    input  logic                          pipe_rst_n,
    output logic                          imem_req,
    output type_scr1_mem_cmd_e            imem_cmd,
    output logic [`SCR1_IMEM_AWIDTH-1:0]  imem_addr,
    input  logic                          imem_req_ack,
    input  logic [`SCR1_IMEM_DWIDTH-1:0]  imem_rdata,
    input  type_scr1_mem_resp_e           imem_resp,
    input  logic                          redirect,
    input  logic [31:0]                   redirect_pc,
    output logic                          fetch_valid,
    output logic [31:0]                   fetch_instr,
    output logic [31:0]                   fetch_pc,
    output logic                          fetch_err,
    input  logic                          fetch_ready
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = $clog2(DEPTH + 1);

    fetch_state_e       r_state;
    logic               r_run;
    logic [31:0]        r_addr;
    logic [c_cnt_w-1:0] r_outstanding;
    logic [c_cnt_w-1:0] r_discard;
    logic [31:0]        r_pcq [DEPTH];
    logic [c_ptr_w-1:0] r_pcq_wr;
    logic [c_ptr_w-1:0] r_pcq_rd;

    logic [c_cnt_w-1:0]   w_entries;
    logic [c_cnt_w:0]     w_credit;
    logic                 w_accept;
    logic                 w_resp_any;
    logic                 w_resp;
    logic                 w_resp_err;
    logic                 w_push;
    logic                 w_pop;
    fetch_entry_t         w_wr_entry;
    logic [c_entry_w-1:0] w_head_bits;
    fetch_entry_t         w_head;

    // A response arriving with nothing outstanding is a protocol violation and
    // is not counted at all, so it cannot corrupt the credit bookkeeping.
    always_comb begin
        w_resp_any = (imem_resp == SCR1_MEM_RESP_RDY_OK) ||
                     (imem_resp == SCR1_MEM_RESP_RDY_ER);
        w_resp     = w_resp_any && (r_outstanding != '0);
        w_resp_err = (imem_resp == SCR1_MEM_RESP_RDY_ER);
        w_credit   = {1'b0, w_entries} + {1'b0, r_outstanding};
        imem_req   = r_run && (r_state == FETCH) && !redirect &&
                     (w_credit < (c_cnt_w + 1)'(DEPTH));
        w_accept   = imem_req && imem_req_ack;
        w_push     = w_resp && !redirect && (r_discard == '0);
        w_pop      = fetch_valid && fetch_ready && !redirect;
        w_wr_entry = '{instr: imem_rdata, pc: r_pcq[r_pcq_rd], err: w_resp_err};
    end

    always_ff @(posedge clk or negedge pipe_rst_n) begin
        if (!pipe_rst_n) begin
            r_run         <= 1'b0;
            r_state       <= FETCH;
            r_addr        <= RST_VECTOR;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_pcq_wr      <= '0;
            r_pcq_rd      <= '0;
        end else begin
            r_run         <= 1'b1;
            r_outstanding <= r_outstanding + c_cnt_w'(w_accept) - c_cnt_w'(w_resp);

            // Requests already in flight at a redirect still complete; their
            // responses are swallowed by the discard counter.
            if (redirect) begin
                r_discard <= r_outstanding - c_cnt_w'(w_resp);
            end else if (w_resp && (r_discard != '0)) begin
                r_discard <= r_discard - c_cnt_w'(1);
            end

            if (redirect) begin
                r_addr <= redirect_pc & 32'hFFFF_FFFC;
            end else if (w_accept) begin
                r_addr <= r_addr + 32'd4;
            end

            if (w_accept) begin
                r_pcq_wr <= r_pcq_wr + c_ptr_w'(1);
            end
            if (w_resp) begin
                r_pcq_rd <= r_pcq_rd + c_ptr_w'(1);
            end

            if (redirect) begin
                r_state <= FETCH;
            end else if (w_push && w_resp_err) begin
                r_state <= HALT_ERR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_pcq[r_pcq_wr] <= r_addr;
        end
    end

    ssrv_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (c_entry_w)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (pipe_rst_n),
        .i_flush (redirect),
        .i_push  (w_push),
        .i_wdata (w_wr_entry),
        .i_pop   (w_pop),
        .o_valid (fetch_valid),
        .o_rdata (w_head_bits),
        .o_count (w_entries)
    );

    assign w_head      = fetch_entry_t'(w_head_bits);
    assign fetch_instr = w_head.instr;
    assign fetch_pc    = w_head.pc;
    assign fetch_err   = w_head.err;
    assign imem_cmd    = SCR1_MEM_CMD_RD;
    assign imem_addr   = r_addr;

`ifndef SYNTHESIS
    a_depth_legal : assert property (@(posedge clk) depth_ok(DEPTH));
    a_resp_has_request : assert property (@(posedge clk) disable iff (!pipe_rst_n)
        w_resp_any |-> (r_outstanding != '0));
`endif

endmodule

`default_nettype wire

// File: tb/tb_ssrv_imem_prefetch.sv
// ============================================================================
//  Module      : tb_ssrv_imem_prefetch
//  Description : Scoreboard bench: memory model, pc/instr/err queue, scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ssrv_imem_prefetch;
    import scr1_memif_pkg::*;

    localparam int DEPTH = 4;

    logic                clk = 1'b0;
    logic                pipe_rst_n;
    logic                imem_req;
    type_scr1_mem_cmd_e  imem_cmd;
    logic [31:0]         imem_addr;
    logic                imem_req_ack;
    logic [31:0]         imem_rdata;
    type_scr1_mem_resp_e imem_resp;
    logic                redirect;
    logic [31:0]         redirect_pc;
    logic                fetch_valid;
    logic [31:0]         fetch_instr;
    logic [31:0]         fetch_pc;
    logic                fetch_err;
    logic                fetch_ready;

    typedef struct packed {
        logic [31:0] addr;
        logic        stale;
    } req_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        err;
    } exp_t;

    req_t        pend_q[$];
    exp_t        exp_q[$];
    logic [31:0] acc_log[$];
    bit          ack_en;
    bit          resp_en;
    logic [31:0] err_addr;
    int          n_checks = 0;
    int          n_pass   = 0;

    ssrv_imem_prefetch #(
        .DEPTH      (DEPTH),
        .RST_VECTOR (32'h0000_0200)
    ) dut (
        .clk          (clk),
        .pipe_rst_n   (pipe_rst_n),
        .imem_req     (imem_req),
        .imem_cmd     (imem_cmd),
        .imem_addr    (imem_addr),
        .imem_req_ack (imem_req_ack),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .fetch_valid  (fetch_valid),
        .fetch_instr  (fetch_instr),
        .fetch_pc     (fetch_pc),
        .fetch_err    (fetch_err),
        .fetch_ready  (fetch_ready)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return {addr[15:0], addr[31:16]} ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] log_at(input int idx);
        if (idx < acc_log.size()) return acc_log[idx];
        return 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One clock cycle, entered and left at the falling edge.
    task automatic step();
        req_t r;
        exp_t e;
        bit   resp_now;
        resp_now = resp_en && (pend_q.size() > 0);
        if (resp_now) begin
            r          = pend_q[0];
            imem_resp  = (r.addr == err_addr) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
            imem_rdata = mem_word(r.addr);
        end else begin
            imem_resp  = SCR1_MEM_RESP_NOTRDY;
            imem_rdata = '0;
        end
        imem_req_ack = ack_en;
        #1;
        if (fetch_valid && fetch_ready && !redirect) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                check("fetch_pc", fetch_pc, e.pc);
                check("fetch_instr", fetch_instr, e.instr);
                check("fetch_err", 32'(fetch_err), 32'(e.err));
            end
        end
        if (redirect) exp_q.delete();
        if (resp_now) begin
            r = pend_q.pop_front();
            if (!redirect && !r.stale)
                exp_q.push_back('{instr: mem_word(r.addr), pc: r.addr, err: (r.addr == err_addr)});
        end
        if (redirect) begin
            for (int i = 0; i < pend_q.size(); i++) begin
                r = pend_q[i];
                r.stale = 1'b1;
                pend_q[i] = r;
            end
        end
        if (imem_req && imem_req_ack) begin
            pend_q.push_back('{addr: imem_addr, stale: 1'b0});
            acc_log.push_back(imem_addr);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect_pc = pc;
        redirect    = 1'b1;
        step();
        redirect    = 1'b0;
    endtask

    task automatic drain();
        ack_en  = 1'b0;
        resp_en = 1'b1;
        repeat (4) step();
    endtask

    initial begin
        pipe_rst_n   = 1'b0;
        imem_req_ack = 1'b0;
        imem_rdata   = '0;
        imem_resp    = SCR1_MEM_RESP_NOTRDY;
        redirect     = 1'b0;
        redirect_pc  = '0;
        fetch_ready  = 1'b0;
        ack_en       = 1'b0;
        resp_en      = 1'b0;
        err_addr     = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);

        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("rst_fetch_err", 32'(fetch_err), 32'd0);
        check("rst_imem_addr", imem_addr, 32'h0000_0200);
        check("rst_fetch_pc", fetch_pc, 32'd0);
        check("rst_fetch_instr", fetch_instr, 32'd0);
        check("imem_cmd", 32'(imem_cmd), 32'(SCR1_MEM_CMD_RD));

        pipe_rst_n = 1'b1;
        #1;
        check("req_before_edge", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("req_after_edge", 32'(imem_req), 32'd1);

        // In-order streaming from the reset vector
        ack_en = 1'b1; resp_en = 1'b1; fetch_ready = 1'b1;
        acc_log.delete();
        repeat (12) step();
        check("seq_addr0", log_at(0), 32'h0000_0200);
        check("seq_addr1", log_at(1), 32'h0000_0204);
        check("seq_addr2", log_at(2), 32'h0000_0208);

        // Credit limit with a stalled consumer
        fetch_ready = 1'b0;
        acc_log.delete();
        do_redirect(32'h0000_0400);
        repeat (12) step();
        check("full_req_count", 32'(acc_log.size()), 32'd4);
        check("full_req_low", 32'(imem_req), 32'd0);
        check("full_valid", 32'(fetch_valid), 32'd1);
        fetch_ready = 1'b1;
        step();
        fetch_ready = 1'b0;
        repeat (8) step();
        check("refill_count", 32'(acc_log.size()), 32'd5);
        check("refill_addr", log_at(4), 32'h0000_0410);

        // Unacknowledged request holds its address
        fetch_ready = 1'b1;
        ack_en = 1'b0;
        do_redirect(32'h0000_0800);
        acc_log.delete();
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_addr", imem_addr, 32'h0000_0800);
            check("stall_req", 32'(imem_req), 32'd1);
        end
        check("stall_no_accept", 32'(acc_log.size()), 32'd0);
        ack_en = 1'b1;
        step();
        check("stall_release", log_at(0), 32'h0000_0800);

        // Redirect with two requests in flight
        drain();
        resp_en = 1'b0; ack_en = 1'b1;
        do_redirect(32'h0000_0600);
        acc_log.delete();
        step();
        step();
        check("two_outstanding", 32'(acc_log.size()), 32'd2);
        do_redirect(32'h0000_1002);
        check("redir_addr", imem_addr, 32'h0000_1000);
        resp_en = 1'b1;
        for (int i = 0; i < 10 && !fetch_valid; i++) step();
        check("redir_valid", 32'(fetch_valid), 32'd1);
        check("redir_first_pc", fetch_pc, 32'h0000_1000);

        // Error response halts fetching until redirect
        drain();
        err_addr = 32'h0000_0208;
        fetch_ready = 1'b0; ack_en = 1'b1;
        do_redirect(32'h0000_0200);
        acc_log.delete();
        repeat (10) step();
        check("halt_req_count", 32'(acc_log.size()), 32'd4);
        check("halt_req_low", 32'(imem_req), 32'd0);
        fetch_ready = 1'b1;
        step();
        step();
        fetch_ready = 1'b0;
        check("err_head_valid", 32'(fetch_valid), 32'd1);
        check("err_head_pc", fetch_pc, 32'h0000_0208);
        check("err_head_err", 32'(fetch_err), 32'd1);
        fetch_ready = 1'b1;
        repeat (6) step();
        check("halt_no_req", 32'(acc_log.size()), 32'd4);
        err_addr = 32'hFFFF_FFFF;
        do_redirect(32'h0000_0300);
        repeat (2) step();
        check("halt_resume", log_at(4), 32'h0000_0300);

        // Address wrap
        drain();
        ack_en = 1'b1;
        do_redirect(32'hFFFF_FFFC);
        acc_log.delete();
        repeat (4) step();
        check("wrap_addr0", log_at(0), 32'hFFFF_FFFC);
        check("wrap_addr1", log_at(1), 32'h0000_0000);

        // Back-to-back redirects keep the last target
        redirect = 1'b1;
        redirect_pc = 32'h0000_0700;
        step();
        redirect_pc = 32'h0000_0900;
        step();
        redirect = 1'b0;
        check("redir_last", imem_addr, 32'h0000_0900);

        // Asynchronous reset with requests in flight
        resp_en = 1'b0; ack_en = 1'b1;
        repeat (2) step();
        #2;
        pipe_rst_n = 1'b0;
        #1;
        check("arst_imem_req", 32'(imem_req), 32'd0);
        check("arst_fetch_valid", 32'(fetch_valid), 32'd0);
        check("arst_imem_addr", imem_addr, 32'h0000_0200);
        check("arst_fetch_pc", fetch_pc, 32'd0);
        pend_q.delete();
        exp_q.delete();
        @(negedge clk);
        pipe_rst_n = 1'b1;
        resp_en = 1'b1;
        acc_log.delete();
        repeat (6) step();
        check("arst_restart", log_at(0), 32'h0000_0200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
